// File: rtl/saa_result_drain.sv
// saa_result_drain: streams the N*N result matrix C from memory out over a valid/ready port
// after the accelerator's completion edge. Define DRAIN_CHECKSUM_EN for a running checksum.
module saa_result_drain #(
  parameter int N      = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  localparam int RC_W  = (N > 1) ? $clog2(N) : 1,
  localparam int K_W   = (N > 1) ? $clog2(N * N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              complete,
  input  logic [ADDR_W-1:0] base_address_C,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RC_W-1:0]   out_row,
  output logic [RC_W-1:0]   out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [K_W-1:0]  K_LAST   = K_W'(N * N - 1);
  localparam logic [RC_W-1:0] COL_LAST = RC_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    PRESENT,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              complete_q;
  logic [ADDR_W-1:0] base_q;
  logic [K_W-1:0]    k_q;
  logic [RC_W-1:0]   row_q, col_q;
  logic              arm;
  logic              start;
  logic              handshake;

  assign arm       = complete && !complete_q;
  assign start     = (state_q == IDLE) && arm;
  assign handshake = (state_q == PRESENT) && out_ready;
  assign mem_addr  = base_q + ADDR_W'(k_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (arm) state_d = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: state_d = PRESENT;
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (k_q == K_LAST) ? FINISH : ISSUE;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Edge detector resets high so a completion flag already asserted at reset release cannot arm.
  // Row/col are tracked as counters alongside k, avoiding a divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      complete_q <= 1'b1;
      base_q     <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
    end else begin
      complete_q <= complete;
      if (start) begin
        base_q <= base_address_C;
        k_q    <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end
      if (state_q == CAPTURE) begin
        out_data <= mem_rdata;
        out_row  <= row_q;
        out_col  <= col_q;
        out_last <= (k_q == K_LAST);
      end
      if (handshake && (k_q != K_LAST)) begin
        k_q <= k_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Final sum stays put after done until the next drain starts.
  always_ff @(posedge clk) begin
    if (rst)            sum_q <= '0;
    else if (start)     sum_q <= '0;
    else if (handshake) sum_q <= sum_q + out_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_saa_result_drain.sv
// tb_saa_result_drain: vector table plus randomized drains checked against a matrix-level model.
// Expects checksum = word sum when DRAIN_CHECKSUM_EN is defined, else 0.
module tb_saa_result_drain;

  localparam int N      = 5;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RC_W   = $clog2(N);
  localparam int NN     = N * N;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              complete;
  logic [ADDR_W-1:0] base_address_C;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RC_W-1:0]   out_row;
  logic [RC_W-1:0]   out_col;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] got_data [$];
  int                got_row  [$];
  int                got_col  [$];
  bit                got_last [$];
  int                addr_log [$];
  int                done_count;

  typedef struct {
    int base;
    int mode;
    int exp_first;
    int exp_last;
    int exp_sum;
  } vec_t;

  vec_t vecs [5];

  saa_result_drain #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .complete       (complete),
    .base_address_C (base_address_C),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Negedge monitor: collects accepted words and read addresses, checks hold stability and pulse widths.
  bit                hold_pending = 0;
  logic [DATA_W-1:0] hold_data;
  logic [RC_W-1:0]   hold_row, hold_col;
  logic              hold_last;
  bit                prev_rd = 0;
  bit                prev_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
      prev_rd      = 0;
      prev_done    = 0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, hold_data);
        checkOutput("hold_row", out_row, hold_row);
        checkOutput("hold_col", out_col, hold_col);
        checkOutput("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_row.push_back(int'(out_row));
        got_col.push_back(int'(out_col));
        got_last.push_back(out_last);
      end
      if (mem_rd_en) begin
        addr_log.push_back(int'(mem_addr));
        checkOutput("rd_en_one_cycle", prev_rd, 0);
        checkOutput("rd_en_while_valid", out_valid, 0);
      end
      if (done) begin
        done_count++;
        checkOutput("done_one_cycle", prev_done, 0);
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_row     = out_row;
      hold_col     = out_col;
      hold_last    = out_last;
      prev_rd      = mem_rd_en;
      prev_done    = done;
    end
  end

  function automatic int expected_checksum(input int sum);
`ifdef DRAIN_CHECKSUM_EN
    return sum;
`else
    return 0;
`endif
  endfunction

  task automatic fill_sequential(input int base);
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'($urandom);
    for (int k = 0; k < NN; k++) mem[(base + k) % DEPTH] = DATA_W'(k + 1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'($urandom);
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 random ready.
  // glitch_at / reset_at (>=0) inject a complete re-edge or a reset once that many words are accepted.
  task automatic run_drain(input int base, input int mode, input int glitch_at, input int reset_at,
                           output bit aborted);
    int cycles;
    bit seen_valid;
    bit glitched;
    got_data.delete();
    got_row.delete();
    got_col.delete();
    got_last.delete();
    addr_log.delete();
    done_count     = 0;
    aborted        = 0;
    seen_valid     = 0;
    glitched       = 0;
    cycles         = 0;
    base_address_C = ADDR_W'(base);
    complete       = 1'b0;
    out_ready      = 1'b1;
    @(posedge clk); #1;
    complete = 1'b1;
    while (done_count == 0 && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        checkOutput("busy_after_arm", busy, 1);
        base_address_C = ~ADDR_W'(base);
      end
      if (!seen_valid && out_valid) begin
        seen_valid = 1;
        checkOutput("first_valid_latency", cycles, 3);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cycles[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (glitch_at >= 0 && !glitched && got_data.size() == glitch_at) begin
        complete = 1'b0;
        glitched = 1;
      end else begin
        complete = 1'b1;
      end
      if (reset_at >= 0 && got_data.size() == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_mid_valid", out_valid, 0);
        checkOutput("reset_mid_busy", busy, 0);
        checkOutput("reset_mid_rd_en", mem_rd_en, 0);
        rst     = 1'b0;
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      checkOutput("drain_timeout", cycles < 2000, 1);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("done_count", done_count, 1);
      checkOutput("busy_after_done", busy, 0);
    end
  endtask

  // Reference model: word k comes from mem[(base+k) mod 2^ADDR_W] at row k/N, col k%N.
  task automatic verify_drain(input int base);
    int                a;
    logic [DATA_W-1:0] exp_word;
    logic [DATA_W-1:0] exp_sum;
    exp_sum = '0;
    checkOutput("word_count", got_data.size(), NN);
    checkOutput("read_count", addr_log.size(), NN);
    for (int k = 0; k < NN; k++) begin
      a        = (base + k) % DEPTH;
      exp_word = mem[a];
      exp_sum  = exp_sum + exp_word;
      if (k < got_data.size()) begin
        checkOutput($sformatf("data[%0d]", k), got_data[k], exp_word);
        checkOutput($sformatf("row[%0d]", k), got_row[k], k / N);
        checkOutput($sformatf("col[%0d]", k), got_col[k], k % N);
        checkOutput($sformatf("last[%0d]", k), got_last[k], (k == NN - 1) ? 1 : 0);
      end
      if (k < addr_log.size()) checkOutput($sformatf("addr[%0d]", k), addr_log[k], a);
    end
    checkOutput("checksum", checksum, expected_checksum(int'(exp_sum)));
  endtask

  task automatic applyStimulus(input vec_t v);
    bit aborted;
    fill_sequential(v.base);
    run_drain(v.base, v.mode, -1, -1, aborted);
    checkOutput("vec_first_word", (got_data.size() > 0) ? got_data[0] : 0, v.exp_first);
    checkOutput("vec_last_word", (got_data.size() == NN) ? got_data[NN-1] : 0, v.exp_last);
    checkOutput("vec_checksum", checksum, expected_checksum(v.exp_sum));
    verify_drain(v.base);
  endtask

  initial begin
    bit aborted;
    int idle_activity;

    vecs[0] = '{base: 50,  mode: 0, exp_first: 1, exp_last: 25, exp_sum: 325};
    vecs[1] = '{base: 50,  mode: 1, exp_first: 1, exp_last: 25, exp_sum: 325};
    vecs[2] = '{base: 250, mode: 0, exp_first: 1, exp_last: 25, exp_sum: 325};
    vecs[3] = '{base: 231, mode: 2, exp_first: 1, exp_last: 25, exp_sum: 325};
    vecs[4] = '{base: 0,   mode: 1, exp_first: 1, exp_last: 25, exp_sum: 325};

    rst            = 1'b1;
    complete       = 1'b0;
    out_ready      = 1'b0;
    base_address_C = 8'd77;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mem_rd_en", mem_rd_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_row", out_row, 0);
    checkOutput("rst_out_col", out_col, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_checksum", checksum, 0);

    // complete already high at reset release must not start a drain
    complete  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    idle_activity = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy || out_valid || mem_rd_en) idle_activity++;
    end
    checkOutput("held_complete_no_arm", idle_activity, 0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // checksum holds its final value while idle
    repeat (5) @(posedge clk);
    #1;
    checkOutput("checksum_hold_idle", checksum, expected_checksum(325));

    // second completion edge mid-drain is ignored
    fill_sequential(50);
    run_drain(50, 0, 10, -1, aborted);
    verify_drain(50);

    // reset during word 12, then a fresh edge restarts from word 1
    fill_sequential(50);
    run_drain(50, 1, -1, 11, aborted);
    checkOutput("reset_aborted", aborted, 1);
    checkOutput("reset_words_seen", got_data.size(), 11);
    run_drain(50, 0, -1, -1, aborted);
    verify_drain(50);

    for (int t = 0; t < 6; t++) begin
      int b;
      b = $urandom_range(0, DEPTH - 1);
      fill_random();
      run_drain(b, 2, -1, -1, aborted);
      verify_drain(b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
